// File: rtl/nonrestoring_divider_seq_pkg.sv
// Shared definitions for the sequential non-restoring divider: FSM encodings,
// debug record and the sign-bit index helper.
package nonrestoring_divider_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

   typedef struct packed {
      state_e state;
      logic   row_cout;
   } dbg_t;

   // The partial remainder is WIDTH+1 bits wide, so its sign lives at index WIDTH.
   function automatic int sign_idx(input int width);
      return width;
   endfunction

endpackage

// File: rtl/nonrestoring_divider_seq_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
// start is sampled only while the divider is idle; done is a one-cycle pulse
// qualifying quotient/remainder/div_by_zero, which hold until the next result.
interface nonrestoring_divider_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/nonrestoring_divider_seq_cas_row.sv
// One row of controlled add/subtract cells: p_o = p_i - d_i when sub_i, else p_i + d_i.
// Subtraction inverts d and injects sub_i as the carry into bit 0.
module nonrestoring_divider_seq_cas_row #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0] p_i,
   input  logic [WIDTH:0] d_i,
   input  logic           sub_i,
   output logic [WIDTH:0] p_o,
   output logic           carry_o
);

   logic [WIDTH+1:0] c;

   assign c[0] = sub_i;

   for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
      logic b;
      assign b        = d_i[i] ^ sub_i;
      assign p_o[i]   = p_i[i] ^ b ^ c[i];
      assign c[i+1]   = (p_i[i] & b) | (c[i] & (p_i[i] ^ b));
   end

   assign carry_o = c[WIDTH+1];

endmodule

// File: rtl/nonrestoring_divider_seq.sv
// Sequential unsigned non-restoring divider, one add/subtract row per clock.
// Optional macro DIV_ZERO_DETECT_EN: zero divisor answers in one cycle without running.
module nonrestoring_divider_seq
   import nonrestoring_divider_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   nonrestoring_divider_seq_if.slave   bus,
   output dbg_t                        dbg_o
);

   localparam int SIGN  = sign_idx(WIDTH);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_e             state_q;
   logic [WIDTH:0]     p_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH:0]     d_q;
   logic [CNT_W-1:0]   count_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   quotient_q;
   logic [WIDTH-1:0]   remainder_q;
   logic               dbz_q;

   logic [WIDTH:0]     row_in;
   logic               row_sub;
   logic [WIDTH:0]     p_d;
   logic               row_cout;
   logic [WIDTH:0]     p_fix_d;

   // RUN feeds the shifted remainder and picks add/sub from the old sign;
   // FIX reuses the same row as a plain adder to restore a negative remainder.
   assign row_in  = (state_q == FIX) ? p_q : {p_q[WIDTH-1:0], a_q[WIDTH-1]};
   assign row_sub = (state_q == RUN) ? ~p_q[SIGN] : 1'b0;
   assign p_fix_d = p_q[SIGN] ? p_d : p_q;

   nonrestoring_divider_seq_cas_row #(.WIDTH(WIDTH)) u_row (
      .p_i     (row_in),
      .d_i     (d_q),
      .sub_i   (row_sub),
      .p_o     (p_d),
      .carry_o (row_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         p_q         <= '0;
         a_q         <= '0;
         d_q         <= '0;
         count_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  d_q     <= {1'b0, bus.divisor};
                  count_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
                  if (bus.divisor == '0) begin
                     // Preload the known answer; FIX then publishes it unchanged.
                     p_q     <= {1'b0, bus.dividend};
                     a_q     <= '1;
                     state_q <= FIX;
                  end else begin
                     p_q     <= '0;
                     a_q     <= bus.dividend;
                     busy_q  <= 1'b1;
                     state_q <= RUN;
                  end
`else
                  p_q     <= '0;
                  a_q     <= bus.dividend;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
`endif
               end
            end
            RUN: begin
               p_q     <= p_d;
               a_q     <= {a_q[WIDTH-2:0], ~p_d[SIGN]};
               count_q <= count_q + CNT_W'(1);
               if (count_q == LAST) begin
                  busy_q  <= 1'b0;
                  state_q <= FIX;
               end
            end
            FIX: begin
               p_q         <= p_fix_d;
               quotient_q  <= a_q;
               remainder_q <= p_fix_d[WIDTH-1:0];
               dbz_q       <= (d_q == '0);
               done_q      <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;

   assign dbg_o.state    = state_q;
   assign dbg_o.row_cout = row_cout;

endmodule
